controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 206 ++++++++++++++++++++
 tb/tb_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// Multicycle RISC-V control FSM: decodes state plus opcode/func fields into datapath selects and enables.
// Latency: outputs are combinational from the current state, 3-5 cycles per instruction. No backpressure.
// Optional TRAP_ILLEGAL_EN: an unknown opcode parks the FSM in HALT with illegal=1 until reset.
module controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7b5,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       Carry,
    input  logic       Overflow,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_A = 2'b10, SRCA_ZERO = 2'b11;
    localparam logic [1:0] SRCB_WD = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000, ALU_SRA = 4'b1001;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic       regw_raw, irw_raw, pcw_raw, memw_raw;
    logic [3:0] alu_op;
    logic       taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Shared ALU decode for register and immediate arithmetic; SUB only exists for R-type.
    always_comb begin
        alu_op = ALU_ADD;
        case (func3)
            3'b000: alu_op = (state == S_EXECR && func7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = func7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    // Carry is the no-borrow flag of A-B, so unsigned less-than is !Carry.
    always_comb begin
        taken = 1'b0;
        case (func3)
            3'b000: taken = Zero;
            3'b001: taken = !Zero;
            3'b100: taken = Negative ^ Overflow;
            3'b101: taken = !(Negative ^ Overflow);
            3'b110: taken = !Carry;
            3'b111: taken = Carry;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        regw_raw   = 1'b0;
        irw_raw    = 1'b0;
        pcw_raw    = 1'b0;
        memw_raw   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_WD;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                irw_raw   = 1'b1;
                pcw_raw   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (op == OP_BR)       ImmSrc = IMM_B;
                else if (op == OP_JAL) ImmSrc = IMM_J;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BR:             state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR;
                    OP_LUI:            state_nxt = S_LUI;
                    OP_AUIPC:          state_nxt = S_AUIPC;
`ifdef TRAP_ILLEGAL_EN
                    default:           state_nxt = S_HALT;
`else
                    default:           state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_A;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = (op == OP_STORE) ? IMM_S : IMM_I;
                state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                regw_raw  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                memw_raw  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_A;
                ALUControl = alu_op;
                state_nxt  = S_ALUWB;
            end
            S_EXECI, S_JALR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ALUControl = (state == S_EXECI) ? alu_op : ALU_ADD;
                state_nxt  = (state == S_EXECI) ? S_ALUWB : S_JAL;
            end
            S_ALUWB: begin
                regw_raw  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUControl = ALU_SUB;
                pcw_raw    = taken;
                state_nxt  = S_FETCH;
            end
            // Jumps: PC takes the target already in ALUOut while the ALU forms OldPC+4 for rd.
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pcw_raw   = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_LUI, S_AUIPC: begin
                ALUSrcA   = (state == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_U;
                state_nxt = S_ALUWB;
            end
            S_HALT: begin
`ifdef TRAP_ILLEGAL_EN
                illegal   = 1'b1;
                state_nxt = S_HALT;
`else
                state_nxt = S_FETCH;
`endif
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Enables are killed combinationally while reset is held so nothing commits mid-reset.
    assign RegWrite = regw_raw & reset;
    assign IRWrite  = irw_raw  & reset;
    assign PCWrite  = pcw_raw  & reset;
    assign MemWrite = memw_raw & reset;

endmodule

// File: tb/tb_controller.sv
// Randomized bench for controller: an instruction-level model produces the expected per-cycle
// control word sequence, checked every cycle, plus directed literal checks.
module tb_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] func3;
    logic       func7b5, Zero, Negative, Carry, Overflow;
    logic       RegWrite, IRWrite, AdrSrc, PCWrite, MemWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    typedef struct packed {
        logic       regw, irw, adr, pcw, memw;
        logic [1:0] res, srca, srcb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } outs_t;

    outs_t act;
    outs_t exp_q[$];
    outs_t seq[$];
    outs_t cap[0:15];
    int    n_cyc;
    int    n_chk = 0;
    int    n_pass = 0;

    controller dut (
        .clk(clk), .reset(reset), .op(op), .func3(func3), .func7b5(func7b5),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .PCWrite(PCWrite),
        .MemWrite(MemWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = {RegWrite, IRWrite, AdrSrc, PCWrite, MemWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, ALUControl, illegal};

    task automatic chk(input string name, input int a, input int e);
        n_chk++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, a, e);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && exp_q.size() > 0) begin
            outs_t e;
            e = exp_q.pop_front();
            n_chk++;
            if (act === e) n_pass++;
            else $display("FAIL cycle_word op=%b f3=%b: got %h expected %h at %0t",
                          op, func3, act, e, $time);
        end
    end

    function automatic outs_t mk(input logic rw, iw, ad, pw, mw, input logic [1:0] rs, sa, sb,
                                 input logic [2:0] im, input logic [3:0] al, input logic il);
        outs_t o;
        o = {rw, iw, ad, pw, mw, rs, sa, sb, im, al, il};
        return o;
    endfunction

    function automatic logic [3:0] alu_for(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // Branch outcome from what the flags mean for A-B, not from a flag table.
    function automatic logic br_taken(input logic [2:0] f3, input logic z, n, c, v);
        logic lt_s, lt_u;
        lt_s = n ^ v;
        lt_u = !c;
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt_s;
            3'd5: return !lt_s;
            3'd6: return lt_u;
            3'd7: return !lt_u;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, n, c, v);
        outs_t aluwb, jal;
        logic [2:0] dimm;
        aluwb = mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0);
        jal   = mk(0, 0, 0, 1, 0, 2'd0, 2'd1, 2'd2, 3'd0, 4'd0, 0);
        dimm  = (o == 7'b1100011) ? 3'd2 : (o == 7'b1101111) ? 3'd3 : 3'd0;
        seq.delete();
        seq.push_back(mk(0, 1, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, 4'd0, 0));
        seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, dimm, 4'd0, 0));
        case (o)
            7'b0000011: begin
                seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0, 0));
                seq.push_back(mk(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
                seq.push_back(mk(1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 4'd0, 0));
            end
            7'b0100011: begin
                seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 4'd0, 0));
                seq.push_back(mk(0, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
            end
            7'b0110011: begin
                seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, alu_for(f3, f7, 1), 0));
                seq.push_back(aluwb);
            end
            7'b0010011: begin
                seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, alu_for(f3, f7, 0), 0));
                seq.push_back(aluwb);
            end
            7'b1100011:
                seq.push_back(mk(0, 0, 0, br_taken(f3, z, n, c, v), 0, 2'd0, 2'd2, 2'd0, 3'd0, 4'd1, 0));
            7'b1101111: begin
                seq.push_back(jal);
                seq.push_back(aluwb);
            end
            7'b1100111: begin
                seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0, 0));
                seq.push_back(jal);
                seq.push_back(aluwb);
            end
            7'b0110111, 7'b0010111: begin
                seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, (o == 7'b0110111) ? 2'd3 : 2'd1, 2'd1, 3'd4, 4'd0, 0));
                seq.push_back(aluwb);
            end
            default: begin
`ifdef TRAP_ILLEGAL_EN
                for (int k = 0; k < 10; k++)
                    seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1));
`endif
            end
        endcase
    endtask

    // Called one posedge+2 before the FETCH cycle; returns at posedge+2 after the last cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [3:0] fl);
        op = o; func3 = f3; func7b5 = f7;
        {Zero, Negative, Carry, Overflow} = fl;
        build(o, f3, f7, fl[3], fl[2], fl[1], fl[0]);
        n_cyc = seq.size();
        foreach (seq[k]) exp_q.push_back(seq[k]);
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            if (k < 16) cap[k] = act;
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int count_bit(input int which);
        int s = 0;
        for (int k = 0; k < n_cyc && k < 16; k++)
            s += (which == 0) ? int'(cap[k].regw) : (which == 1) ? int'(cap[k].memw) : int'(cap[k].ill);
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops[9];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        reset = 1'b0; op = '0; func3 = '0; func7b5 = 1'b0;
        {Zero, Negative, Carry, Overflow} = 4'b0;
        #3;
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_alusrcb", ALUSrcB, 2);
        chk("rst_resultsrc", ResultSrc, 2);
        chk("rst_illegal", illegal, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        run_instr(7'b0010011, 3'b000, 1'b0, 4'b0000);
        chk("addi_len", n_cyc, 4);
        chk("addi_alu", cap[2].alu, 0);
        chk("addi_srcb", cap[2].srcb, 1);
        chk("addi_regw_last", cap[3].regw, 1);
        chk("addi_regw_once", count_bit(0), 1);
        run_instr(7'b0110011, 3'b000, 1'b1, 4'b0000);
        chk("sub_alu", cap[2].alu, 1);
        run_instr(7'b0010011, 3'b000, 1'b1, 4'b0000);
        chk("addi_f7_alu", cap[2].alu, 0);
        run_instr(7'b1100011, 3'b100, 1'b0, 4'b0100);
        chk("blt_taken", cap[2].pcw, 1);
        chk("br_len", n_cyc, 3);
        run_instr(7'b1100011, 3'b100, 1'b0, 4'b0101);
        chk("blt_not_taken", cap[2].pcw, 0);
        run_instr(7'b1100011, 3'b111, 1'b0, 4'b0000);
        chk("bgeu_c0", cap[2].pcw, 0);
        run_instr(7'b0000011, 3'b010, 1'b0, 4'b0000);
        chk("lw_len", n_cyc, 5);
        chk("lw_adrsrc", cap[3].adr, 1);
        chk("lw_resultsrc", cap[4].res, 1);
        chk("lw_regw", cap[4].regw, 1);
        run_instr(7'b0100011, 3'b010, 1'b0, 4'b0000);
        chk("sw_len", n_cyc, 4);
        chk("sw_memw_once", count_bit(1), 1);
        run_instr(7'b1100111, 3'b000, 1'b0, 4'b0000);
        chk("jalr_len", n_cyc, 5);
        chk("jalr_pcw", cap[3].pcw, 1);
        run_instr(7'b1101111, 3'b000, 1'b0, 4'b0000);
        chk("jal_len", n_cyc, 4);

        run_instr(7'b1111111, 3'b000, 1'b0, 4'b0000);
`ifdef TRAP_ILLEGAL_EN
        chk("halt_illegal_cycles", count_bit(2), 10);
        chk("halt_still", illegal, 1);
        reset = 1'b0;
        #1;
        chk("halt_rst_illegal", illegal, 0);
        chk("halt_rst_srcb", ALUSrcB, 2);
        @(posedge clk);
        #2 reset = 1'b1;
`else
        chk("nop_len", n_cyc, 2);
        chk("nop_illegal", count_bit(2), 0);
`endif
        run_instr(7'b0010011, 3'b110, 1'b0, 4'b0000);

        op = 7'b0100011; func3 = 3'b010; func7b5 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("swr_memw_before", MemWrite, 1);
        reset = 1'b0;
        #1;
        chk("swr_memw_drop", MemWrite, 0);
        chk("swr_irw", IRWrite, 0);
        chk("swr_pcw", PCWrite, 0);
        chk("swr_adrsrc", AdrSrc, 0);
        chk("swr_srcb", ALUSrcB, 2);
        repeat (2) @(posedge clk);
        #2;
        chk("swr_hold_irw", IRWrite, 0);
        chk("swr_hold_memw", MemWrite, 0);
        reset = 1'b1;
        run_instr(7'b0010011, 3'b000, 1'b0, 4'b0000);

        for (int i = 0; i < 300; i++) begin
            logic [6:0] o;
            int sel;
`ifdef TRAP_ILLEGAL_EN
            sel = $urandom_range(0, 8);
`else
            sel = $urandom_range(0, 9);
`endif
            if (sel < 9) o = ops[sel];
            else begin
                o = 7'($urandom_range(0, 127));
                while (is_legal(o)) o = 7'($urandom_range(0, 127));
            end
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)));
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
